// File: rtl/ex_muldiv_ctrl.sv
// RV32M multiply/divide sequencer for the execute stage.
// Iterative shift-add multiplier and restoring divider, 32 steps per op.
module ex_muldiv_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  funct3,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic        flush,
    output logic        stall,
    output logic        done,
    output logic [31:0] result
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [4:0]  count;
    logic [2:0]  op;
    logic [31:0] opnd;
    logic [63:0] acc;
    logic        neg_q;
    logic        neg_r;

    logic        is_div;
    logic        sgn_a;
    logic        sgn_b;
    logic        neg_a;
    logic        neg_b;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic        div_zero;
    logic        div_ovf;
    logic        fast;
    logic [31:0] fast_res;
    logic        launch;

    assign is_div = funct3[2];
    assign sgn_a  = (funct3 == 3'd1) || (funct3 == 3'd2) ||
                    (funct3 == 3'd4) || (funct3 == 3'd6);
    assign sgn_b  = (funct3 == 3'd1) || (funct3 == 3'd4) ||
                    (funct3 == 3'd6);
    assign neg_a  = sgn_a && op_a[31];
    assign neg_b  = sgn_b && op_b[31];
    assign mag_a  = neg_a ? -op_a : op_a;
    assign mag_b  = neg_b ? -op_b : op_b;

    // Cases the iterative divider cannot produce are answered immediately.
    assign div_zero = is_div && (op_b == 32'd0);
    assign div_ovf  = is_div && !funct3[0] &&
                      (op_a == 32'h8000_0000) &&
                      (op_b == 32'hFFFF_FFFF);
    assign fast     = div_zero || div_ovf;
    assign fast_res = div_zero ? (funct3[1] ? op_a : 32'hFFFF_FFFF)
                               : (funct3[1] ? 32'd0 : 32'h8000_0000);

    assign launch = (state == IDLE) && start && !flush;

    // Multiply: {hi, lo} holds partial product above the multiplier bits.
    logic [32:0] mul_sum;
    logic [63:0] mul_step;

    assign mul_sum  = {1'b0, acc[63:32]} +
                      (acc[0] ? {1'b0, opnd} : 33'd0);
    assign mul_step = {mul_sum, acc[31:1]};

    // Divide: hi holds the partial remainder, lo shifts quotient bits in.
    logic [32:0] div_shl;
    logic        div_ge;
    logic [31:0] div_sub;
    logic [63:0] div_step;

    assign div_shl  = acc[63:31];
    assign div_ge   = div_shl >= {1'b0, opnd};
    assign div_sub  = div_shl[31:0] - opnd;
    assign div_step = div_ge ? {div_sub, acc[30:0], 1'b1}
                             : {div_shl[31:0], acc[30:0], 1'b0};

    logic [63:0] acc_step;
    logic [63:0] prod;
    logic [31:0] quot;
    logic [31:0] rem;
    logic [31:0] run_res;

    assign acc_step = op[2] ? div_step : mul_step;
    assign prod     = neg_q ? -acc_step : acc_step;
    assign quot     = neg_q ? -acc_step[31:0] : acc_step[31:0];
    assign rem      = neg_r ? -acc_step[63:32] : acc_step[63:32];

    always_comb begin
        run_res = prod[63:32];
        case (op)
            3'd0:       run_res = prod[31:0];
            3'd4, 3'd5: run_res = quot;
            3'd6, 3'd7: run_res = rem;
            default:    run_res = prod[63:32];
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        case (state)
            IDLE: begin
                if (start && !flush) begin
                    stall     = 1'b1;
                    state_nxt = fast ? DONE : RUN;
                end
            end
            RUN: begin
                if (flush) begin
                    state_nxt = IDLE;
                end else begin
                    stall = 1'b1;
                    if (count == 5'd31) begin
                        state_nxt = DONE;
                    end
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count  <= 5'd0;
            op     <= 3'd0;
            opnd   <= 32'd0;
            acc    <= 64'd0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            result <= 32'd0;
        end else if (launch) begin
            count <= 5'd0;
            op    <= funct3;
            neg_q <= neg_a ^ neg_b;
            neg_r <= neg_a;
            opnd  <= is_div ? mag_b : mag_a;
            acc   <= {32'd0, is_div ? mag_a : mag_b};
            if (fast) begin
                result <= fast_res;
            end
        end else if (state == RUN) begin
            if (flush) begin
                count <= 5'd0;
            end else begin
                acc   <= acc_step;
                count <= count + 5'd1;
                if (count == 5'd31) begin
                    result <= run_res;
                end
            end
        end
    end

    assign done = (state == DONE);

endmodule

// File: tb/tb_ex_muldiv_ctrl.sv
// Self-checking bench for ex_muldiv_ctrl.
// Random and directed M-ops checked against a 64-bit arithmetic model.
module tb_ex_muldiv_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        flush;
    logic        stall;
    logic        done;
    logic [31:0] result;

    int tests_run;
    int tests_failed;
    logic [31:0] last_res;

    ex_muldiv_ctrl dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .funct3 (funct3),
        .op_a   (op_a),
        .op_b   (op_b),
        .flush  (flush),
        .stall  (stall),
        .done   (done),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] model(input logic [2:0] f,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        int          sa;
        int          sb;
        longint      ps;
        longint unsigned pu;
        longint      ub;
        logic [63:0] p;
        sa = a;
        sb = b;
        ub = {32'd0, b};
        model = 32'd0;
        case (f)
            3'd0: begin
                ps = longint'(sa) * longint'(sb);
                p = ps;
                model = p[31:0];
            end
            3'd1: begin
                ps = longint'(sa) * longint'(sb);
                p = ps;
                model = p[63:32];
            end
            3'd2: begin
                ps = longint'(sa) * ub;
                p = ps;
                model = p[63:32];
            end
            3'd3: begin
                pu = longint'({32'd0, a}) * longint'({32'd0, b});
                p = pu;
                model = p[63:32];
            end
            3'd4: begin
                if (b == 0) model = 32'hFFFF_FFFF;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                    model = 32'h8000_0000;
                else model = sa / sb;
            end
            3'd5: model = (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) model = a;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                    model = 32'd0;
                else model = sa % sb;
            end
            default: model = (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int model_lat(input logic [2:0] f,
                                     input logic [31:0] a,
                                     input logic [31:0] b);
        bit ovf;
        ovf = (f == 3'd4 || f == 3'd6) &&
              a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
        if (f >= 3'd4 && (b == 0 || ovf)) return 1;
        return 33;
    endfunction

    // Issue one op at the next negedge; hold start until done,
    // scrambling operands while stalled.
    task automatic run_op(input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp,
                          input int lat, input string name);
        int c;
        int nst;
        bit got;
        @(negedge clk);
        start = 1'b1;
        funct3 = f;
        op_a = a;
        op_b = b;
        c = 0;
        nst = 0;
        got = 0;
        while (!got && c < 60) begin
            #1;
            if (done) begin
                got = 1;
                start = 1'b0;
            end else begin
                if (stall) nst++;
                c++;
                @(posedge clk);
                #1;
                op_a = $urandom;
                op_b = $urandom;
                @(negedge clk);
            end
        end
        tests_run++;
        if (!got) begin
            tests_failed++;
            $display("FAIL %s timeout: no done in 60 cycles", name);
            start = 1'b0;
        end else begin
            if (result !== exp || c != lat || nst != lat || stall !== 1'b0) begin
                tests_failed++;
                $display("FAIL %s f=%0d a=%h b=%h: result=%h lat=%0d stall_cyc=%0d stall_at_done=%b, required result=%h lat=%0d stall_at_done=0",
                         name, f, a, b, result, c, nst, stall, exp, lat);
            end
            last_res = exp;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        start = 1'b0;
        flush = 1'b0;
        funct3 = 3'd0;
        op_a = 32'd0;
        op_b = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        tests_run++;
        if (stall !== 1'b0 || done !== 1'b0 || result !== 32'd0) begin
            tests_failed++;
            $display("FAIL reset: stall=%b done=%b result=%h, required 0 0 0",
                     stall, done, result);
        end
        last_res = 32'd0;
    endtask

    task automatic test_directed;
        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, "mul");
        run_op(3'd1, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33, "mulh");
        run_op(3'd3, 32'd7, 32'hFFFF_FFFD, 32'h0000_0006, 33, "mulhu");
        run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 33, "mulhsu");
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, "div");
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, "rem");
        run_op(3'd5, 32'd100, 32'd7, 32'd14, 33, "divu");
    endtask

    task automatic test_fast_path;
        run_op(3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, "divu_by_0");
        run_op(3'd6, 32'd5, 32'd0, 32'd5, 1, "rem_by_0");
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "div_ovf");
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, "rem_ovf");
        run_op(3'd4, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 1, "div_by_0");
        run_op(3'd7, 32'hDEAD_BEEF, 32'd0, 32'hDEAD_BEEF, 1, "remu_by_0");
    endtask

    task automatic test_random;
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        for (int i = 0; i < 48; i++) begin
            f = 3'($urandom_range(7, 0));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(7, 0))
                0: b = 32'd0;
                1: b = 32'($urandom_range(15, 1));
                2: a = 32'h8000_0000;
                3: b = 32'hFFFF_FFFF;
                default: ;
            endcase
            run_op(f, a, b, model(f, a, b), model_lat(f, a, b), "random");
        end
    endtask

    task automatic test_flush;
        int bad;
        // Flush together with start: nothing launches.
        @(negedge clk);
        start = 1'b1;
        flush = 1'b1;
        funct3 = 3'd0;
        op_a = 32'd3;
        op_b = 32'd5;
        #1;
        tests_run++;
        if (stall !== 1'b0) begin
            tests_failed++;
            $display("FAIL flush_vs_start: stall=%b, required 0", stall);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        flush = 1'b0;
        // Flush at count 10 of a running MUL.
        @(negedge clk);
        start = 1'b1;
        funct3 = 3'd0;
        op_a = 32'h0001_0001;
        op_b = 32'h0000_0100;
        repeat (11) @(posedge clk);
        @(negedge clk);
        #1;
        tests_run++;
        if (stall !== 1'b1) begin
            tests_failed++;
            $display("FAIL flush_pre_stall: stall=%b, required 1", stall);
        end
        flush = 1'b1;
        #1;
        tests_run++;
        if (stall !== 1'b0) begin
            tests_failed++;
            $display("FAIL flush_stall_drop: stall=%b, required 0", stall);
        end
        @(posedge clk);
        #1;
        flush = 1'b0;
        start = 1'b0;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done !== 1'b0 || stall !== 1'b0 || result !== last_res) bad++;
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL flush_quiet: %0d bad cycles (done/stall/result), required 0, result=%h required %h",
                     bad, result, last_res);
        end
        run_op(3'd0, 32'h0001_0001, 32'h0000_0100, 32'h0100_0100, 33, "mul_after_flush");
    endtask

    task automatic test_reset_mid_op;
        @(negedge clk);
        start = 1'b1;
        funct3 = 3'd5;
        op_a = 32'd1000;
        op_b = 32'd3;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        start = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tests_run++;
        if (stall !== 1'b0 || done !== 1'b0 || result !== 32'd0) begin
            tests_failed++;
            $display("FAIL reset_mid_op: stall=%b done=%b result=%h, required 0 0 0",
                     stall, done, result);
        end
        last_res = 32'd0;
        run_op(3'd5, 32'd1000, 32'd3, 32'd333, 33, "divu_after_reset");
    endtask

    task automatic test_back_to_back;
        run_op(3'd6, 32'd17, 32'd5, 32'd2, 33, "b2b_rem");
        run_op(3'd5, 32'd9, 32'd0, 32'hFFFF_FFFF, 1, "b2b_fast");
        run_op(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 33, "b2b_mul");
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, "b2b_mulhu");
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        test_reset();
        test_directed();
        test_fast_path();
        test_flush();
        test_reset_mid_op();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/ex_muldiv_ctrl.md
# ex_muldiv_ctrl

Multi-cycle sequencer for the RV32M multiply/divide operations issued from the execute stage. It latches the forwarded operands of a valid M-extension instruction, runs an iterative 32-step shift-add multiplier or restoring divider, and holds the pipeline with `stall` until the result is ready. On completion it presents the result for one cycle, which the execute stage muxes in place of the ALU result. It sits beside the ALU in execute: its `stall` gates the pipeline `enable`, and it obeys the same `flush` as the execute register.

## Interface
Parameters:
- none; the width is fixed at 32 (RV32M).

Ports:
- `clk`  in  1  pipeline clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `start`  in  1  a valid M-op is in execute; driven as `v_de && is_muldiv`.
- `funct3`  in  3  operation select:
  - 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU
  - 4 DIV, 5 DIVU, 6 REM, 7 REMU
- `op_a`  in  32  forwarded rs1 value, after the bypass mux.
- `op_b`  in  32  forwarded rs2 value, after the bypass mux.
- `flush`  in  1  same flush as the execute stage; kills any operation in flight.
- `stall`  out  1  hold execute and all earlier stages (`enable` = !stall at the pipeline level).
- `done`  out  1  `result` is valid this cycle.
- `result`  out  32  operation result.

## Operation
- States: IDLE, RUN, DONE. A 5-bit iteration counter runs alongside.
- IDLE → RUN:
  - Condition: `start && !flush`.
  - Latch operand magnitudes and result signs; clear the accumulator; set count = 0.
- Fast path, IDLE → DONE directly (the RUN state is skipped):
  - Divide-by-zero (`op_b` == 0):
    - DIV and DIVU give 0xFFFFFFFF.
    - REM and REMU give `op_a`.
  - Signed overflow (DIV or REM with `op_a` = 0x80000000 and `op_b` = 0xFFFFFFFF):
    - DIV gives 0x80000000.
    - REM gives 0.
- RUN iterations:
  - Multiply: one shift-add step per cycle into a 64-bit accumulator.
  - Divide: one restoring step per cycle.
  - Count increments each cycle. At count == 31 the state moves to DONE and `result` is registered with the sign fixed.
- Signed handling (operands as magnitudes, sign applied at the end):
  - MULH: both operands signed.
  - MULHSU: `op_a` signed, `op_b` unsigned.
  - MULHU, DIVU, REMU: both operands unsigned.
  - Quotient sign = sign(a) XOR sign(b).
  - Remainder sign = sign(a).
- Result selection:
  - MUL returns the low 32 bits of the product.
  - MULH, MULHSU and MULHU return the high 32 bits.
- DONE → IDLE unconditionally. `start` is ignored in DONE: the same instruction is still in execute and leaves this cycle.
- `flush` in any state:
  - Next state is IDLE.
  - `done` is not asserted; `result` is not updated.
  - Flush has priority over `start`.
- Reset (`rst_n` low at a clock edge):
  - State = IDLE, count = 0, `result` = 0, `done` = 0.
  - Reset mid-operation abandons the operation.

## Timing
- `stall` is combinational:
  - Asserted when `(IDLE && start && !flush) || (RUN && !flush)`.
  - Deasserted in DONE.
  - During and immediately after reset it is 0 unless `start` is high.
- `done` is registered: 1 exactly when the state is DONE.
- Iterative path, with `start` first seen at cycle T:
  - `stall` is high for cycles T through T+32 (33 cycles).
  - `done` is high at T+33.
  - Execute samples `result` at the T+33 edge (enable high).
- Fast path:
  - `stall` is high at T only.
  - `done` is high at T+1.
- Operands are sampled only at T. Later changes on `op_a`/`op_b` (for example, bypass sources shifting while stalled) have no effect.
- Back-to-back M-ops: the second `start` is seen in the cycle after DONE, so a minimum of 1 IDLE cycle separates the two operations.
- `result` holds its value until the next completion.

## Test plan
- Reset with `start` = 0 → `stall` = 0, `done` = 0, `result` = 0.
- MUL of 0x00000007 and 0xFFFFFFFD → `stall` high for 33 cycles, then `done` = 1 with `result` = 0xFFFFFFEB.
- Same operand pair:
  - MULH → 0xFFFFFFFF.
  - MULHU → 0x00000006.
  - MULHSU with `op_a` = 0xFFFFFFFF, `op_b` = 2 → 0xFFFFFFFF.
- DIV of -7 by 2 → 0xFFFFFFFD; REM of -7 by 2 → 0xFFFFFFFF; DIVU of 100 by 7 → 14.
- Fast paths, each with `done` at T+1:
  - DIVU of 5 by 0 → 0xFFFFFFFF.
  - REM of 5 by 0 → 5.
  - DIV of 0x80000000 by 0xFFFFFFFF → 0x80000000.
- `flush` at RUN count = 10 → `stall` drops in the same cycle, no `done` pulse, `result` is unchanged. A new MUL then started completes correctly in 33 cycles.
